// File: rtl/scroll_controller.sv
// -----------------------------------------------------------------------------
// scroll_controller
//   Command-side initiator for the rotating 16-bit row registers of the LED
//   panel. Conditions three raw push-buttons, runs a STOP/RUN/PAUSE state
//   machine, paces shifts with a prescaler and tracks the rotation offset.
//   One instance drives every row register in parallel through ch1/ch0.
//
// Ports:
//   CLK         in   system clock, rising edge
//   RST_N       in   asynchronous active-low reset
//   btn_run_n   in   raw run/pause button, active-low, asynchronous
//   btn_dir_n   in   raw direction-toggle button, active-low, asynchronous
//   btn_stop_n  in   raw stop button, active-low, asynchronous
//   ch0, ch1    out  registered mode code {ch1,ch0}:
//                    00 stop/reload, 01 shift R->L, 10 shift L->R, 11 hold
//   shift_tick  out  one-CLK strobe, high while a shift code is presented
//   offset      out  current rotation offset, 0..ROW_LEN-1
//   running     out  high in RUN
//   dir_l2r     out  0 = right-to-left, 1 = left-to-right
// -----------------------------------------------------------------------------
module scroll_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SHIFT_DIV       = 12500000,
  parameter int unsigned ROW_LEN         = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       btn_run_n,
  input  logic       btn_dir_n,
  input  logic       btn_stop_n,
  output logic       ch0,
  output logic       ch1,
  output logic       shift_tick,
  output logic [3:0] offset,
  output logic       running,
  output logic       dir_l2r
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PS_W = $clog2(SHIFT_DIV);

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(SHIFT_DIV - 1);
  localparam logic [3:0]      OFF_LAST = 4'(ROW_LEN - 1);

  localparam logic [1:0] ST_STOP  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [1:0] CODE_STOP = 2'b00;
  localparam logic [1:0] CODE_R2L  = 2'b01;
  localparam logic [1:0] CODE_L2R  = 2'b10;
  localparam logic [1:0] CODE_HOLD = 2'b11;

  // Button index: 0 = run, 1 = dir, 2 = stop
  logic [2:0]      btnRaw;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      level_q, level_d;
  logic [2:0]      press_q, press_d;
  logic [DB_W-1:0] dbCnt_q [3];
  logic [DB_W-1:0] dbCnt_d [3];

  logic [1:0]      state_q, state_d;
  logic [PS_W-1:0] psCnt_q, psCnt_d;
  logic [1:0]      code_q, code_d;
  logic            shiftTick_q, shiftTick_d;
  logic [3:0]      offset_q, offset_d;
  logic            dir_q, dir_d;
  logic            tick;

  assign btnRaw = {btn_stop_n, btn_dir_n, btn_run_n};

  // Debounce: the accepted level only moves after DEBOUNCE_CYCLES samples in
  // a row disagree with it. A press is the accepted 1->0 edge, registered so
  // it lasts exactly one CLK no matter how long the button is held.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      dbCnt_d[i] = dbCnt_q[i];
      level_d[i] = level_q[i];
      press_d[i] = 1'b0;
      if (sync2_q[i] != level_q[i]) begin
        if (dbCnt_q[i] == DB_LAST) begin
          level_d[i] = sync2_q[i];
          dbCnt_d[i] = '0;
          press_d[i] = ~sync2_q[i];
        end else begin
          dbCnt_d[i] = dbCnt_q[i] + 1'b1;
        end
      end else begin
        dbCnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      level_q <= 3'b111;
      press_q <= 3'b000;
      for (int i = 0; i < 3; i++) dbCnt_q[i] <= '0;
    end else begin
      sync1_q <= btnRaw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      for (int i = 0; i < 3; i++) dbCnt_q[i] <= dbCnt_d[i];
    end
  end

  // State machine; a stop press always beats a simultaneous run press.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP:  if (press_q[0] && !press_q[2]) state_d = ST_RUN;
      ST_RUN: begin
        if (press_q[2])      state_d = ST_STOP;
        else if (press_q[0]) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (press_q[2])      state_d = ST_STOP;
        else if (press_q[0]) state_d = ST_RUN;
      end
      default:  state_d = ST_STOP;
    endcase
  end

  // A tick only counts if we stay in RUN; leaving RUN on the same cycle
  // suppresses the shift. The tick uses the direction held before any
  // coinciding dir press, which only lands in dir_q on the next edge.
  always_comb begin
    tick        = (state_q == ST_RUN) && (state_d == ST_RUN) && (psCnt_q == PS_LAST);
    dir_d       = dir_q ^ press_q[1];
    shiftTick_d = tick;

    if ((state_d != ST_RUN) || (state_q != ST_RUN) || (psCnt_q == PS_LAST)) psCnt_d = '0;
    else                                                                  psCnt_d = psCnt_q + 1'b1;

    code_d   = CODE_HOLD;
    offset_d = offset_q;
    case (state_d)
      ST_STOP: begin
        code_d   = CODE_STOP;
        offset_d = 4'd0;
      end
      ST_RUN: begin
        if (tick) begin
          if (dir_q) begin
            code_d   = CODE_L2R;
            offset_d = (offset_q == 4'd0) ? OFF_LAST : offset_q - 4'd1;
          end else begin
            code_d   = CODE_R2L;
            offset_d = (offset_q == OFF_LAST) ? 4'd0 : offset_q + 4'd1;
          end
        end
      end
      default: code_d = CODE_HOLD;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_STOP;
      psCnt_q     <= '0;
      code_q      <= CODE_STOP;
      shiftTick_q <= 1'b0;
      offset_q    <= 4'd0;
      dir_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      psCnt_q     <= psCnt_d;
      code_q      <= code_d;
      shiftTick_q <= shiftTick_d;
      offset_q    <= offset_d;
      dir_q       <= dir_d;
    end
  end

  assign ch0        = code_q[0];
  assign ch1        = code_q[1];
  assign shift_tick = shiftTick_q;
  assign offset     = offset_q;
  assign running    = (state_q == ST_RUN);
  assign dir_l2r    = dir_q;

endmodule

// File: tb/tb_scroll_controller.sv
// -----------------------------------------------------------------------------
// tb_scroll_controller
//   Randomised button sequences against a shift-level reference model.
//   Stimulus pushes the shifts it expects (code, resulting offset) into a
//   queue; the monitor pops one every time shift_tick is seen and also checks
//   the shift spacing against SHIFT_DIV. Steady-state outputs are checked
//   after each button operation settles.
// -----------------------------------------------------------------------------
module tb_scroll_controller;

  localparam int DB  = 4;
  localparam int DIV = 8;
  localparam int LEN = 16;

  localparam int M_STOP  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       btnRunN = 1'b1;
  logic       btnDirN = 1'b1;
  logic       btnStopN = 1'b1;
  logic       ch0, ch1, shift_tick, running, dir_l2r;
  logic [3:0] offset;

  scroll_controller #(
    .DEBOUNCE_CYCLES(DB),
    .SHIFT_DIV      (DIV),
    .ROW_LEN        (LEN)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .btn_run_n (btnRunN),
    .btn_dir_n (btnDirN),
    .btn_stop_n(btnStopN),
    .ch0       (ch0),
    .ch1       (ch1),
    .shift_tick(shift_tick),
    .offset    (offset),
    .running   (running),
    .dir_l2r   (dir_l2r)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] code;
    logic [3:0] off;
  } expT;

  expT expQ[$];

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: panel state, offset and direction
  int mState = M_STOP;
  int mOff   = 0;
  bit mDir   = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Each shift moves the offset by one, wrapping around the row
  task automatic pushShifts(input int k);
    for (int i = 0; i < k; i++) begin
      if (mDir) mOff = (mOff + LEN - 1) % LEN;
      else      mOff = (mOff + 1) % LEN;
      expQ.push_back({(mDir ? 2'b10 : 2'b01), 4'(mOff)});
    end
  endtask

  // Monitor: scoreboard pop on every strobe, plus spacing between strobes
  int cyc = 0;
  bit prevRunning = 1'b0;
  bit refValid = 1'b0;
  int refCyc = 0;

  always @(negedge CLK) begin
    expT e;
    bit  isShiftCode;
    cyc++;
    isShiftCode = ({ch1, ch0} == 2'b01) || ({ch1, ch0} == 2'b10);
    checkOutput("tickMatchesCode", int'(shift_tick), int'(isShiftCode));
    if (running && !prevRunning) begin
      refValid = 1'b1;
      refCyc   = cyc;
    end
    if (shift_tick) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpectedShift: got code %0d offset %0d, expected no shift at %0t",
                 {ch1, ch0}, offset, $time);
      end else begin
        e = expQ.pop_front();
        checkOutput("shiftCode", int'({ch1, ch0}), int'(e.code));
        checkOutput("shiftOffset", int'(offset), int'(e.off));
      end
      if (refValid) checkOutput("shiftSpacing", cyc - refCyc, DIV);
      refValid = running;
      refCyc   = cyc;
    end
    if (!running) refValid = 1'b0;
    prevRunning = running;
  end

  task automatic setBtn(input int which, input logic val);
    case (which)
      0:       btnRunN  = val;
      1:       btnDirN  = val;
      default: btnStopN = val;
    endcase
  endtask

  // Clean press: held low for lowCycles, then released long enough to settle
  task automatic applyStimulus(input int which, input int lowCycles);
    setBtn(which, 1'b0);
    repeat (lowCycles) @(negedge CLK);
    setBtn(which, 1'b1);
    repeat (12) @(negedge CLK);
  endtask

  task automatic bouncePress();
    btnRunN = 1'b0; repeat (2) @(negedge CLK);
    btnRunN = 1'b1; repeat (1) @(negedge CLK);
    btnRunN = 1'b0; repeat (2) @(negedge CLK);
    btnRunN = 1'b1; repeat (1) @(negedge CLK);
    btnRunN = 1'b0; repeat (10) @(negedge CLK);
    btnRunN = 1'b1; repeat (12) @(negedge CLK);
  endtask

  // Returns just after the strobe that empties the queue
  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 400) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drainTimeout: got %0d pending shifts, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  task automatic checkSteady(input string tag);
    #1;
    checkOutput({tag, ".running"}, int'(running), int'(mState == M_RUN));
    checkOutput({tag, ".dir"}, int'(dir_l2r), int'(mDir));
    if (mState == M_RUN) begin
      checkOutput({tag, ".offset"}, int'(offset), mOff);
    end else begin
      checkOutput({tag, ".code"}, int'({ch1, ch0}), (mState == M_STOP) ? 0 : 3);
      checkOutput({tag, ".offset"}, int'(offset), (mState == M_STOP) ? 0 : mOff);
      checkOutput({tag, ".pending"}, expQ.size(), 0);
    end
  endtask

  // Operations. Presses issued while running start three cycles after a
  // strobe, so the press lands well between two tick decisions; the strobe
  // due before it lands is still expected with the old settings.
  task automatic opRunPress(input int k, input bit bouncy);
    @(negedge CLK);
    if (mState == M_RUN) begin
      repeat (2) @(negedge CLK);
      pushShifts(1);
      mState = M_PAUSE;
      applyStimulus(0, 10);
      checkSteady("pause");
    end else begin
      if (mState == M_PAUSE || mState == M_STOP) mState = M_RUN;
      pushShifts(k);
      if (bouncy) bouncePress();
      else        applyStimulus(0, 10);
      waitDrain();
      checkSteady("run");
    end
  endtask

  task automatic opStop();
    @(negedge CLK);
    if (mState == M_RUN) begin
      repeat (2) @(negedge CLK);
      pushShifts(1);
    end
    mState = M_STOP;
    mOff   = 0;
    applyStimulus(2, 10);
    checkSteady("stop");
  endtask

  task automatic opDir(input int k);
    @(negedge CLK);
    if (mState == M_RUN) begin
      repeat (2) @(negedge CLK);
      pushShifts(1);
      mDir = ~mDir;
      pushShifts(k);
      applyStimulus(1, 10);
      waitDrain();
    end else begin
      mDir = ~mDir;
      applyStimulus(1, 10);
    end
    checkSteady("dir");
  endtask

  task automatic opStopRun();
    @(negedge CLK);
    mState   = M_STOP;
    mOff     = 0;
    btnRunN  = 1'b0;
    btnStopN = 1'b0;
    repeat (10) @(negedge CLK);
    btnRunN  = 1'b1;
    btnStopN = 1'b1;
    repeat (12) @(negedge CLK);
    checkSteady("stopRun");
  endtask

  task automatic opGlitch();
    @(negedge CLK);
    btnRunN = 1'b0;
    repeat (3) @(negedge CLK);
    btnRunN = 1'b1;
    repeat (12) @(negedge CLK);
    checkSteady("glitch");
  endtask

  task automatic opShifts(input int k);
    pushShifts(k);
    waitDrain();
    checkSteady("shifts");
  endtask

  initial begin
    int r;
    int n;

    // Reset and idle
    repeat (3) @(negedge CLK);
    checkSteady("inReset");
    RST_N = 1'b1;
    repeat (50) @(negedge CLK);
    checkSteady("idle");
    checkOutput("idle.tick", int'(shift_tick), 0);

    // Directed: wrap right-to-left, reverse, pause, stop, bounce, stop+run
    opRunPress(17, 1'b0);
    opDir(4);
    opRunPress(0, 1'b0);
    opStop();
    opRunPress(3, 1'b1);
    opRunPress(0, 1'b0);
    opStopRun();
    opGlitch();
    opStop();

    // Randomised operation sequence
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 4));
      case (mState)
        M_STOP: begin
          case (r)
            0:       opRunPress(int'($urandom_range(3, 5)), 1'b0);
            1:       opRunPress(int'($urandom_range(3, 5)), 1'b1);
            2:       opDir(0);
            3:       opStop();
            default: opGlitch();
          endcase
        end
        M_RUN: begin
          case (r)
            0, 1:    opShifts(int'($urandom_range(1, 6)));
            2:       opDir(int'($urandom_range(3, 5)));
            3:       opRunPress(0, 1'b0);
            default: opStop();
          endcase
        end
        default: begin
          case (r)
            0:       opRunPress(int'($urandom_range(3, 5)), 1'b0);
            1:       opStop();
            2:       opStopRun();
            3:       opDir(0);
            default: opGlitch();
          endcase
        end
      endcase
    end

    // Reset pulse during a shift cycle
    if (mState != M_RUN) opRunPress(3, 1'b0);
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (!shift_tick && n < 20);
    checkOutput("preReset.tick", int'(shift_tick), 1);
    RST_N = 1'b0;
    #1;
    checkOutput("rst.code", int'({ch1, ch0}), 0);
    checkOutput("rst.tick", int'(shift_tick), 0);
    checkOutput("rst.offset", int'(offset), 0);
    checkOutput("rst.running", int'(running), 0);
    checkOutput("rst.dir", int'(dir_l2r), 0);
    mState = M_STOP;
    mOff   = 0;
    mDir   = 1'b0;
    expQ.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (40) @(negedge CLK);
    checkSteady("afterReset");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/scroll_controller.md
Name: scroll_controller

Overview:
- Command-side initiator for the 16-bit rotating row registers of the LED panel.
- Turns three raw kit push-buttons (run/pause, direction, stop) into the ch0/ch1 mode code that every row register samples on CLK.
- Paces shifts with a prescaler and tracks the current rotation offset.
- One instance drives all row registers in parallel.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronized samples needed to accept a new button level (10 ms @ 50 MHz).
- SHIFT_DIV, 12500000: CLK cycles between shifts while running (4 Hz @ 50 MHz); must be >= 2.
- ROW_LEN, 16: row register length; offset wraps modulo ROW_LEN.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- btn_run_n  in  1  raw run/pause button, active-low, asynchronous to CLK.
- btn_dir_n  in  1  raw direction-toggle button, active-low, asynchronous.
- btn_stop_n  in  1  raw stop button, active-low, asynchronous.
- ch0  out  1  mode code bit 0 to row registers (registered).
- ch1  out  1  mode code bit 1 to row registers (registered).
- shift_tick  out  1  one-CLK strobe, high in the same cycle a shift code is on ch1/ch0.
- offset  out  4  current rotation offset, 0..ROW_LEN-1.
- running  out  1  high in RUN state.
- dir_l2r  out  1  0 = right-to-left, 1 = left-to-right.

Behaviour:
- Mode code {ch1,ch0}:
  - 00 = stop/reload initial pattern.
  - 01 = shift right-to-left (each flop takes the previous flop).
  - 10 = shift left-to-right (each flop takes the next flop).
  - 11 = hold.
- Reset (RST_N low, async): state STOP, {ch1,ch0}=00, shift_tick=0, offset=0, running=0, dir_l2r=0, prescaler=0, debouncers cleared to released (1).
- Button conditioning, per button:
  - 2-flop synchronizer.
  - Debounced level changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples differing from the current level; any mismatch restarts the count.
  - Press event = debounced 1->0 transition, a single one-CLK pulse. Releases produce no event.
  - Holding a button never repeats the event.
- FSM states STOP, RUN, PAUSE:
  - STOP: press_run -> RUN.
  - RUN: press_run -> PAUSE; press_stop -> STOP.
  - PAUSE: press_run -> RUN; press_stop -> STOP.
  - press_stop in STOP: no effect.
  - Same-cycle press_stop and press_run: stop wins.
- Prescaler:
  - Counts only in RUN; cleared to 0 on every entry to RUN and held at 0 otherwise.
  - Tick when count = SHIFT_DIV-1, then count wraps to 0.
  - The first shift occurs SHIFT_DIV cycles after the RUN state is entered.
- Outputs by state (registered, one CLK after the state/tick decision):
  - STOP: code 00 continuously, offset forced to 0.
  - PAUSE: code 11, offset held.
  - RUN: code 11 except on tick cycles, where the code is 01 (dir_l2r=0) or 10 (dir_l2r=1) for exactly one CLK, with shift_tick=1.
  - Never two consecutive shift cycles.
- Offset update on a shift cycle:
  - 01: offset+1 mod ROW_LEN (15 -> 0).
  - 10: offset-1 mod ROW_LEN (0 -> 15).
- Direction:
  - press_dir toggles dir_l2r in any state.
  - If it coincides with a tick decision, that tick uses the old direction; the new one applies from the next tick.
- RUN->PAUSE or RUN->STOP in the same cycle as a tick decision: no shift is issued, and the offset is unchanged (STOP still zeroes it).
- Reset asserted mid-shift: outputs drop to reset values immediately, with no partial strobe after deassertion.
- running = (state == RUN); dir_l2r is a direct register output.

Test Plan:
- Bench parameters for all scenarios: DEBOUNCE_CYCLES=4, SHIFT_DIV=8.
- Reset then idle 50 cycles -> {ch1,ch0}=00, offset=0, shift_tick never high, running=0.
- Clean press of btn_run_n (held low 20 cycles) -> running=1 about 7 cycles after the press edge; first code 01 with shift_tick exactly 8 cycles after RUN entry, then every 8 cycles; code 11 between shifts; offset 1,2,3...
- Run 17 shifts right-to-left -> offset sequence wraps 15 -> 0 -> 1; press btn_dir_n -> next shifts show code 10, offset 1 -> 0 -> 15.
- btn_run_n bouncing (low 2 / high 1 / low 2 / high 1, then low 10) -> exactly one press event; bounce shorter than 4 cycles alone -> no event.
- In RUN press run (PAUSE: code 11, offset frozen), then press stop -> code 00, offset=0, running=0; stop and run debounced in the same cycle from PAUSE -> STOP.
- RST_N pulsed low 1 cycle during a shift cycle -> ch0/ch1 = 00 and shift_tick=0 asynchronously; after release the state is STOP with no further shifts until a run press.
